// File: rtl/esdi_drive_cmd_responder.sv
// esdi_drive_cmd_responder: drive-side ESDI serial command/status responder
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   transfer_req, command_data       async serial handshake/data from controller
//   transfer_ack, confstat_data      handshake acknowledge and serial status bit
//   command_complete, attention      1 = idle/ready, 1 = error pending
//   cmd_valid, cmd_data              one-cycle pulse with the received command word
//   cmd_done                         local logic finished a non-data command
//   resp_valid, resp_data            status/config word to return (RESP_WAIT only)
//   parity_err                       sticky command parity failure flag
// Optional macro ESDI_RSP_TIMEOUT_EN aborts a word when REQ stalls for TIMEOUT cycles.
// Words are 16 data bits MSB first plus one odd-parity bit. transfer_ack rises
// ACK_DELAY cycles after the cycle in which the synchronized REQ rise is registered.
module esdi_drive_cmd_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY   = 4,
    parameter int TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transfer_req,
    input  logic        command_data,
    output logic        transfer_ack,
    output logic        confstat_data,
    output logic        command_complete,
    output logic        attention,
    output logic        cmd_valid,
    output logic [15:0] cmd_data,
    input  logic        cmd_done,
    input  logic        resp_valid,
    input  logic [15:0] resp_data,
    output logic        parity_err
);
    typedef enum logic [3:0] {
        IDLE, CMD_ACK, CMD_WAIT_LOW, CMD_WAIT_HIGH, CHECK, EXEC,
        RESP_WAIT, RESP_WAIT_HIGH, RESP_ACK, RESP_WAIT_LOW
    } state_t;
    localparam logic [7:0] ACK_LOAD = 8'(ACK_DELAY - 1);
    if (SYNC_STAGES < 2 || ACK_DELAY < 1 || ACK_DELAY > 255 || TIMEOUT < 1) begin : g_bad_param
        $error("esdi_drive_cmd_responder: parameter out of range");
    end
    state_t                 state;
    logic [SYNC_STAGES-1:0] req_sync, dat_sync;
    logic                   req_prev;
    logic                   req_s, dat_s, req_rise;
    logic [16:0]            shreg;
    logic [4:0]             bit_cnt;
    logic [7:0]             ack_cnt;
    assign req_s    = req_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign req_rise = req_s & ~req_prev;
    // REQ chain and its history reset high so a REQ held high through reset
    // never looks like a rising edge; it must be seen low first.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync <= '1;
            dat_sync <= '0;
            req_prev <= 1'b1;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], transfer_req};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], command_data};
            req_prev <= req_s;
        end
    end
`ifdef ESDI_RSP_TIMEOUT_EN
    logic [31:0] to_cnt;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            transfer_ack     <= 1'b0;
            confstat_data    <= 1'b0;
            command_complete <= 1'b1;
            attention        <= 1'b0;
            cmd_valid        <= 1'b0;
            cmd_data         <= '0;
            parity_err       <= 1'b0;
            shreg            <= '0;
            bit_cnt          <= '0;
            ack_cnt          <= '0;
`ifdef ESDI_RSP_TIMEOUT_EN
            to_cnt           <= '0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                IDLE: if (req_rise) begin
                    shreg            <= {16'b0, dat_s};
                    bit_cnt          <= 5'd1;
                    ack_cnt          <= ACK_LOAD;
                    command_complete <= 1'b0;
                    parity_err       <= 1'b0;
                    attention        <= 1'b0;
                    state            <= CMD_ACK;
                end
                CMD_ACK, RESP_ACK: if (ack_cnt == 8'd0) begin
                    transfer_ack <= 1'b1;
                    state        <= (state == CMD_ACK) ? CMD_WAIT_LOW : RESP_WAIT_LOW;
                end else begin
                    ack_cnt <= ack_cnt - 8'd1;
                end
                CMD_WAIT_LOW: if (!req_s) begin
                    transfer_ack <= 1'b0;
                    state        <= (bit_cnt == 5'd17) ? CHECK : CMD_WAIT_HIGH;
                end
                CMD_WAIT_HIGH: if (req_rise) begin
                    shreg   <= {shreg[15:0], dat_s};
                    bit_cnt <= bit_cnt + 5'd1;
                    ack_cnt <= ACK_LOAD;
                    state   <= CMD_ACK;
                end
                // Odd parity: XOR of all 17 bits must be 1. Opcodes 0000/0001
                // (status/config requests) share the top three bits 000.
                CHECK: if (^shreg) begin
                    cmd_valid <= 1'b1;
                    cmd_data  <= shreg[16:1];
                    state     <= (shreg[16:14] == 3'b000) ? RESP_WAIT : EXEC;
                end else begin
                    parity_err       <= 1'b1;
                    attention        <= 1'b1;
                    command_complete <= 1'b1;
                    state            <= IDLE;
                end
                EXEC: if (cmd_done) begin
                    command_complete <= 1'b1;
                    state            <= IDLE;
                end
                RESP_WAIT: if (resp_valid) begin
                    shreg   <= {resp_data, ~^resp_data};
                    bit_cnt <= 5'd0;
                    state   <= RESP_WAIT_HIGH;
                end
                RESP_WAIT_HIGH: if (req_rise) begin
                    confstat_data <= shreg[16];
                    shreg         <= {shreg[15:0], 1'b0};
                    bit_cnt       <= bit_cnt + 5'd1;
                    ack_cnt       <= ACK_LOAD;
                    state         <= RESP_ACK;
                end
                RESP_WAIT_LOW: if (!req_s) begin
                    transfer_ack <= 1'b0;
                    if (bit_cnt == 5'd17) begin
                        command_complete <= 1'b1;
                        confstat_data    <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        state <= RESP_WAIT_HIGH;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef ESDI_RSP_TIMEOUT_EN
            // Only mid-word handshake states are timed; any REQ edge restarts the count.
            if (state inside {IDLE, CHECK, EXEC, RESP_WAIT} || (req_s ^ req_prev)) begin
                to_cnt <= '0;
            end else if (to_cnt == 32'(TIMEOUT - 1)) begin
                to_cnt           <= '0;
                transfer_ack     <= 1'b0;
                confstat_data    <= 1'b0;
                attention        <= 1'b1;
                command_complete <= 1'b1;
                state            <= IDLE;
            end else begin
                to_cnt <= to_cnt + 32'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_esdi_drive_cmd_responder.sv
// tb_esdi_drive_cmd_responder: directed self-checking bench for esdi_drive_cmd_responder
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected ACK latency from REQ rise = SYNC_STAGES sync flops + 1 edge-detect cycle + ACK_DELAY.
module tb_esdi_drive_cmd_responder;
    localparam int SS  = 2;
    localparam int AD  = 4;
    localparam int LAT = SS + 1 + AD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        transfer_req = 1'b0;
    logic        command_data = 1'b0;
    logic        cmd_done = 1'b0;
    logic        resp_valid = 1'b0;
    logic [15:0] resp_data = 16'h0;
    logic        transfer_ack, confstat_data, command_complete, attention, cmd_valid, parity_err;
    logic [15:0] cmd_data;
    int          total = 0;
    int          bad = 0;
    int          vcount = 0;

    esdi_drive_cmd_responder #(.SYNC_STAGES(SS), .ACK_DELAY(AD), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .transfer_req(transfer_req), .command_data(command_data),
        .transfer_ack(transfer_ack), .confstat_data(confstat_data),
        .command_complete(command_complete), .attention(attention),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_done(cmd_done),
        .resp_valid(resp_valid), .resp_data(resp_data), .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (cmd_valid) vcount++;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One REQ/ACK bit exchange; lat = -1 if ACK never rises or never falls.
    task automatic xfer(input logic b, output int lat, output logic cs);
        command_data = b;
        transfer_req = 1'b1;
        lat = -1;
        cs = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (transfer_ack) begin
                lat = i;
                cs = confstat_data;
                break;
            end
        end
        transfer_req = 1'b0;
        for (int i = 0; i < 50 && transfer_ack; i++) @(negedge clk);
        if (transfer_ack) lat = -1;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [16:0] w, input int first, input int n, output int badlat);
        int lat;
        logic cs;
        badlat = 0;
        for (int i = first; i < first + n; i++) begin
            xfer(w[16-i], lat, cs);
            if (lat != LAT) badlat++;
        end
    endtask

    task automatic recv_word(output logic [16:0] r, output int badlat);
        int lat;
        logic cs;
        badlat = 0;
        r = '0;
        for (int i = 0; i < 17; i++) begin
            xfer(1'b0, lat, cs);
            r[16-i] = cs;
            if (lat != LAT) badlat++;
        end
    endtask

    task automatic pulse_done();
        cmd_done = 1'b1;
        cycles(1);
        cmd_done = 1'b0;
        cycles(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(3);
        total++; if (transfer_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", transfer_ack); end
        total++; if (command_complete !== 1'b1) begin bad++; $display("FAIL reset_cc got=%b want=1", command_complete); end
        total++; if ({confstat_data, attention, cmd_valid, parity_err} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {confstat_data, attention, cmd_valid, parity_err}); end
        total++; if (cmd_data !== 16'h0) begin bad++; $display("FAIL reset_cmd_data got=%h want=0000", cmd_data); end
        rst = 1'b0;
        cycles(4);
    endtask

    task automatic test_exec_cmd();
        int bl;
        int v0;
        v0 = vcount;
        send_bits({16'h3005, 1'b1}, 0, 17, bl);
        total++; if (bl !== 0) begin bad++; $display("FAIL exec_ack_latency bad_bits got=%0d want=0", bl); end
        cycles(2);
        total++; if (vcount !== v0 + 1) begin bad++; $display("FAIL exec_valid count got=%0d want=%0d", vcount - v0, 1); end
        total++; if (cmd_data !== 16'h3005) begin bad++; $display("FAIL exec_cmd_data got=%h want=3005", cmd_data); end
        total++; if (command_complete !== 1'b0) begin bad++; $display("FAIL exec_busy got=%b want=0", command_complete); end
        transfer_req = 1'b1;
        cycles(10);
        total++; if (transfer_ack !== 1'b0) begin bad++; $display("FAIL exec_req_ignored ack got=%b want=0", transfer_ack); end
        transfer_req = 1'b0;
        cycles(4);
        pulse_done();
        total++; if (command_complete !== 1'b1) begin bad++; $display("FAIL exec_done_cc got=%b want=1", command_complete); end
    endtask

    task automatic test_status_resp();
        int bl;
        int v0;
        logic [16:0] r;
        v0 = vcount;
        send_bits({16'h0000, 1'b1}, 0, 17, bl);
        cycles(2);
        total++; if (vcount !== v0 + 1 || cmd_data !== 16'h0000) begin bad++; $display("FAIL status_cmd got=%0d/%h want=1/0000", vcount - v0, cmd_data); end
        transfer_req = 1'b1;
        cycles(10);
        total++; if (transfer_ack !== 1'b0) begin bad++; $display("FAIL resp_wait_req_ignored ack got=%b want=0", transfer_ack); end
        transfer_req = 1'b0;
        cycles(4);
        resp_data = 16'h8421;
        resp_valid = 1'b1;
        cycles(1);
        resp_valid = 1'b0;
        resp_data = 16'hFFFF;
        cycles(2);
        total++; if (command_complete !== 1'b0) begin bad++; $display("FAIL resp_busy got=%b want=0", command_complete); end
        recv_word(r, bl);
        total++; if (r !== {16'h8421, 1'b1}) begin bad++; $display("FAIL resp_bits got=%h want=%h", r, {16'h8421, 1'b1}); end
        total++; if (bl !== 0) begin bad++; $display("FAIL resp_ack_latency bad_bits got=%0d want=0", bl); end
        total++; if (command_complete !== 1'b1 || confstat_data !== 1'b0) begin bad++; $display("FAIL resp_end cc/cs got=%b%b want=10", command_complete, confstat_data); end
    endtask

    task automatic test_parity_err();
        int bl;
        int v0;
        v0 = vcount;
        send_bits({16'h0000, 1'b0}, 0, 17, bl);
        cycles(2);
        total++; if (vcount !== v0) begin bad++; $display("FAIL perr_no_valid got=%0d want=0", vcount - v0); end
        total++; if ({parity_err, attention, command_complete} !== 3'b111) begin bad++; $display("FAIL perr_flags got=%b want=111", {parity_err, attention, command_complete}); end
        send_bits({16'h3005, 1'b1}, 0, 1, bl);
        total++; if ({parity_err, attention, command_complete} !== 3'b000) begin bad++; $display("FAIL perr_clear got=%b want=000", {parity_err, attention, command_complete}); end
        send_bits({16'h3005, 1'b1}, 1, 16, bl);
        cycles(2);
        total++; if (vcount !== v0 + 1 || cmd_data !== 16'h3005) begin bad++; $display("FAIL perr_next_cmd got=%0d/%h want=1/3005", vcount - v0, cmd_data); end
        pulse_done();
    endtask

    task automatic test_reset_midword();
        int bl;
        int v0;
        logic [16:0] r;
        send_bits({16'h3005, 1'b1}, 0, 8, bl);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(4);
        total++; if (command_complete !== 1'b1 || transfer_ack !== 1'b0 || cmd_data !== 16'h0) begin bad++; $display("FAIL midrst_state got=%b%b/%h want=10/0000", command_complete, transfer_ack, cmd_data); end
        v0 = vcount;
        send_bits({16'h1000, 1'b0}, 0, 17, bl);
        cycles(2);
        total++; if (vcount !== v0 + 1 || cmd_data !== 16'h1000 || bl !== 0) begin bad++; $display("FAIL midrst_cmd got=%0d/%h/%0d want=1/1000/0", vcount - v0, cmd_data, bl); end
        resp_data = 16'h5A5A;
        resp_valid = 1'b1;
        cycles(1);
        resp_valid = 1'b0;
        recv_word(r, bl);
        total++; if (r !== {16'h5A5A, 1'b1}) begin bad++; $display("FAIL config_resp got=%h want=%h", r, {16'h5A5A, 1'b1}); end
    endtask

    task automatic test_req_drop_early();
        int lat;
        int bl;
        int v0;
        lat = -1;
        command_data = 1'b0;
        transfer_req = 1'b1;
        cycles(1);
        transfer_req = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            if (transfer_ack) begin lat = i; break; end
            @(negedge clk);
        end
        total++; if (lat !== LAT) begin bad++; $display("FAIL early_drop_latency got=%0d want=%0d", lat, LAT); end
        cycles(1);
        total++; if (transfer_ack !== 1'b0) begin bad++; $display("FAIL early_drop_ack_fall got=%b want=0", transfer_ack); end
        cycles(1);
        v0 = vcount;
        send_bits({16'h3005, 1'b1}, 1, 16, bl);
        cycles(2);
        total++; if (vcount !== v0 + 1 || cmd_data !== 16'h3005) begin bad++; $display("FAIL early_drop_cmd got=%0d/%h want=1/3005", vcount - v0, cmd_data); end
        pulse_done();
    endtask

    task automatic test_stall();
        int bl;
        send_bits({16'h3005, 1'b1}, 0, 5, bl);
        cycles(150);
`ifdef ESDI_RSP_TIMEOUT_EN
        total++; if ({attention, command_complete, transfer_ack} !== 3'b110) begin bad++; $display("FAIL stall_timeout got=%b want=110", {attention, command_complete, transfer_ack}); end
`else
        total++; if ({attention, command_complete, transfer_ack} !== 3'b000) begin bad++; $display("FAIL stall_wait got=%b want=000", {attention, command_complete, transfer_ack}); end
`endif
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(4);
    endtask

    task automatic test_req_high_reset();
        int bl;
        int v0;
        rst = 1'b1;
        transfer_req = 1'b1;
        cycles(4);
        rst = 1'b0;
        cycles(20);
        total++; if (transfer_ack !== 1'b0 || command_complete !== 1'b1) begin bad++; $display("FAIL req_high_reset got=%b%b want=01", transfer_ack, command_complete); end
        transfer_req = 1'b0;
        cycles(4);
        v0 = vcount;
        send_bits({16'h3005, 1'b1}, 0, 17, bl);
        cycles(2);
        total++; if (bl !== 0 || vcount !== v0 + 1) begin bad++; $display("FAIL req_high_then_cmd got=%0d/%0d want=0/1", bl, vcount - v0); end
        pulse_done();
    endtask

    initial begin
        test_reset();
        test_exec_cmd();
        test_status_resp();
        test_parity_err();
        test_reset_midword();
        test_req_drop_early();
        test_stall();
        test_req_high_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/esdi_drive_cmd_responder.md
Name: esdi_drive_cmd_responder

Overview:
- Drive-side (target) end of the ESDI serial command/status channel, used for drive emulation and for loopback testing of the controller-side interface.
- Receives 17-bit serial commands on transfer_req/command_data and returns 17-bit status/config words on confstat_data using the same REQ/ACK handshake.
- Drives command_complete and attention toward the controller.
- Hands decoded commands to local drive-model logic and collects its responses.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on transfer_req and command_data inputs (min 2).
- ACK_DELAY, 4, clk cycles from synchronized REQ edge to transfer_ack assertion (1..255).
- TIMEOUT, 65535, clk cycles allowed waiting for a REQ edge mid-word (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- transfer_req  in  1  from controller; asynchronous, synchronized internally
- command_data  in  1  serial command bit from controller; asynchronous
- transfer_ack  out  1  handshake acknowledge to controller
- confstat_data  out  1  serial status/config bit to controller
- command_complete  out  1  1 = idle/ready, 0 = command in progress
- attention  out  1  1 = error pending
- cmd_valid  out  1  one-cycle pulse; cmd_data valid
- cmd_data  out  16  received command word, held until next cmd_valid
- cmd_done  in  1  local logic finished a non-data command
- resp_valid  in  1  resp_data valid; accepted in RESP_WAIT only
- resp_data  in  16  status/config word to return
- parity_err  out  1  sticky; set on a command parity failure, cleared at next command's first bit

Behaviour:
- Reset values:
  - transfer_ack=0, confstat_data=0, command_complete=1, attention=0.
  - cmd_valid=0, cmd_data=0, parity_err=0.
  - Bit counter=0; state IDLE.
- Word format:
  - 16 data bits MSB first (bit 15 first), then 1 parity bit.
  - Odd parity over all 17 bits.
- Handshake, per bit:
  - Controller raises REQ.
  - Responder samples command_data (command phase) or presents confstat_data (response phase) on the synchronized REQ rising edge.
  - transfer_ack=1 exactly ACK_DELAY cycles later.
  - transfer_ack=0 on the cycle after synchronized REQ low is seen.
- States:
  - IDLE: command_complete=1. Synchronized REQ rise -> CMD_ACK; sample bit 15; command_complete=0; clear parity_err and attention.
  - CMD_ACK: count ACK_DELAY, then transfer_ack=1 -> CMD_WAIT_LOW.
  - CMD_WAIT_LOW: REQ low -> transfer_ack=0. If 17 bits received -> CHECK; else -> CMD_WAIT_HIGH.
  - CMD_WAIT_HIGH: REQ rise -> sample next bit -> CMD_ACK.
  - CHECK (1 cycle):
    - Parity bad -> parity_err=1, attention=1, command_complete=1, no cmd_valid -> IDLE.
    - Parity good -> cmd_valid pulse. If cmd_data[15:12] is 0000 (request status) or 0001 (request config) -> RESP_WAIT; else -> EXEC.
  - EXEC: wait for cmd_done -> command_complete=1 -> IDLE.
  - RESP_WAIT: on resp_valid, latch {resp_data, odd parity bit} -> RESP_WAIT_HIGH.
  - RESP_WAIT_HIGH: REQ rise -> confstat_data=current bit -> RESP_ACK.
  - RESP_ACK: count ACK_DELAY, then transfer_ack=1 -> RESP_WAIT_LOW.
  - RESP_WAIT_LOW: REQ low -> transfer_ack=0. After bit 17 -> command_complete=1, confstat_data=0 -> IDLE; else -> RESP_WAIT_HIGH.
- Boundary conditions:
  - REQ already high on leaving reset: ignored until it is seen low, since only edges start bits.
  - REQ dropping before ACK is asserted: the ACK still issues, then drops the cycle after it is asserted (REQ already low).
  - cmd_done outside EXEC and resp_valid outside RESP_WAIT: ignored.
  - REQ edges during EXEC or RESP_WAIT: ignored.
  - rst mid-word: all state returns to reset values in the same cycle; a partial word is discarded.

Optional Feature:
- Macro: ESDI_RSP_TIMEOUT_EN.
- Defined:
  - A counter reloads on every REQ edge in any CMD_* or RESP_* state other than IDLE.
  - Reaching TIMEOUT aborts the word: transfer_ack=0, attention=1, command_complete=1 -> IDLE.
  - A timeout in EXEC or RESP_WAIT is not counted.
- Undefined: no counter; waits indefinitely.

Test Plan:
- Command 0x3005 with parity=1 -> 17 ACKs, each ACK_DELAY=4 cycles after synchronized REQ; cmd_valid with cmd_data=0x3005; command_complete low until cmd_done, then 1.
- Command 0x0000 with parity=1, resp_data=0x8421 -> confstat_data sequence 1000_0100_0010_0001 then parity 1; command_complete=1 after 17th ACK drop.
- Command 0x0000 with parity=0 -> no cmd_valid, parity_err=1, attention=1, command_complete=1; next command's first bit clears parity_err and attention.
- rst asserted after 8 command bits, then command 0x1000 with parity=0 -> clean reception; response phase entered, since opcode 0001 is request config.
- ESDI_RSP_TIMEOUT_EN with TIMEOUT=100: REQ stops after bit 5 -> attention=1, command_complete=1 at cycle 100 after the last edge; without the macro the block stays in CMD_WAIT_HIGH.
- REQ held high through reset release -> no ACK until REQ goes low then high.
